// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the sequential ALU controller: FSM states and opcodes.
// Opcode bit 3 selects the logic group; OP_MUL is the only multi-cycle operation.
package alu_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_RSUB = 4'h2;
    localparam logic [3:0] OP_INCA = 4'h3;
    localparam logic [3:0] OP_INCB = 4'h4;
    localparam logic [3:0] OP_DECA = 4'h5;
    localparam logic [3:0] OP_DECB = 4'h6;
    localparam logic [3:0] OP_MUL  = 4'h7;
    localparam logic [3:0] OP_NOTA = 4'h8;
    localparam logic [3:0] OP_NOTB = 4'h9;
    localparam logic [3:0] OP_AND  = 4'hA;
    localparam logic [3:0] OP_OR   = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_NOR  = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_XNOR = 4'hF;

endpackage

// File: rtl/alu_seq_mul.sv
// W-cycle signed shift-add multiplier working on operand magnitudes.
// start loads the operands; done is high during the last iteration, with product valid alongside it.
module alu_seq_mul #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic           busy;
    logic           neg;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  count;

    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] mag_a;
    logic [W-1:0]   mag_b;
    logic [2*W-1:0] acc_next;

    always_comb begin
        ext_a    = {{W{a[W-1]}}, a};
        mag_a    = a[W-1] ? -ext_a : ext_a;
        mag_b    = b[W-1] ? -b : b;
        acc_next = acc + (mplier[0] ? mcand : '0);
        // Product of magnitudes is negated once at the end when signs differ.
        product  = neg ? -acc_next : acc_next;
        done     = busy && (count == CW'(W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            neg    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            neg    <= a[W-1] ^ b[W-1];
            acc    <= '0;
            mcand  <= mag_a;
            mplier <= mag_b;
            count  <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU front end: accepts one request at a time, computes it in EXEC or the
// multiplier, and holds the result in DONE until the consumer takes it.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     in_sel,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [1:0]     in_tag,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_y,
    output logic [1:0]     out_tag,
    output logic [7:0]     op_count,
    output state_t         fsm_state
);

    localparam logic [2*W-1:0] ONE = {{(2*W-1){1'b0}}, 1'b1};

    state_t         state;
    logic [3:0]     sel_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [1:0]     tag_q;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] alu_y;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    // Handshake: a transfer happens on an edge where valid and ready are both 1.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign fsm_state = state;
    assign mul_start = in_valid && in_ready && (in_sel == OP_MUL);

    always_comb begin
        ext_a = {{W{a_q[W-1]}}, a_q};
        ext_b = {{W{b_q[W-1]}}, b_q};
        alu_y = '0;
        case (sel_q)
            OP_ADD:  alu_y = ext_a + ext_b;
            OP_SUB:  alu_y = ext_a - ext_b;
            OP_RSUB: alu_y = ext_b - ext_a;
            OP_INCA: alu_y = ext_a + ONE;
            OP_INCB: alu_y = ext_b + ONE;
            OP_DECA: alu_y = ext_a - ONE;
            OP_DECB: alu_y = ext_b - ONE;
            OP_NOTA: alu_y = {{W{1'b0}}, ~a_q};
            OP_NOTB: alu_y = {{W{1'b0}}, ~b_q};
            OP_AND:  alu_y = {{W{1'b0}}, a_q & b_q};
            OP_OR:   alu_y = {{W{1'b0}}, a_q | b_q};
            OP_NAND: alu_y = {{W{1'b0}}, ~(a_q & b_q)};
            OP_NOR:  alu_y = {{W{1'b0}}, ~(a_q | b_q)};
            OP_XOR:  alu_y = {{W{1'b0}}, a_q ^ b_q};
            OP_XNOR: alu_y = {{W{1'b0}}, ~(a_q ^ b_q)};
            default: alu_y = '0;
        endcase
    end

    alu_seq_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            out_y    <= '0;
            out_tag  <= '0;
            op_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sel_q <= in_sel;
                        a_q   <= in_a;
                        b_q   <= in_b;
                        tag_q <= in_tag;
                        state <= (in_sel == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_y   <= alu_y;
                    out_tag <= tag_q;
                    state   <= ST_DONE;
                end
                ST_MUL: begin
                    if (mul_done) begin
                        out_y   <= mul_product;
                        out_tag <= tag_q;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE here means no request can be taken on the consume edge.
                    if (out_ready) begin
                        op_count <= op_count + 8'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed scenarios plus randomized requests checked
// against an arithmetic reference model with queued expectations.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_sel = 4'h0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   in_tag = 2'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_y;
    logic [1:0]   out_tag;
    logic [7:0]   op_count;
    state_t       fsm_state;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_count = 8'd0;
    logic [7:0] exp_q[$];

    alu_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .op_count  (op_count),
        .fsm_state (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // reference model: signed integer arithmetic on the operand values
    function automatic logic [7:0] model(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        int         sa;
        int         sb;
        int         r;
        logic [3:0] l;
        logic [7:0] res;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = 0;
        l  = 4'h0;
        if (sel[3] == 1'b0) begin
            case (sel[2:0])
                3'd0: r = sa + sb;
                3'd1: r = sa - sb;
                3'd2: r = sb - sa;
                3'd3: r = sa + 1;
                3'd4: r = sb + 1;
                3'd5: r = sa - 1;
                3'd6: r = sb - 1;
                default: r = sa * sb;
            endcase
            res = r[7:0];
        end else begin
            case (sel[2:0])
                3'd0: l = ~a;
                3'd1: l = ~b;
                3'd2: l = a & b;
                3'd3: l = a | b;
                3'd4: l = ~(a & b);
                3'd5: l = ~(a | b);
                3'd6: l = a ^ b;
                default: l = ~(a ^ b);
            endcase
            res = {4'h0, l};
        end
        return res;
    endfunction

    // driver tasks
    task automatic send_req(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] tag, output logic took);
        @(negedge clk);
        in_sel   = sel;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        took     = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // cyc counts clock edges from the accept edge to the first edge that sees out_valid high
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        exp_count = exp_count + 8'd1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++; if (out_y !== 8'h00) begin bad++; $display("FAIL reset_out_y: got %0h want 0", out_y); end
        total++; if (out_tag !== 2'd0) begin bad++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
        total++; if (op_count !== 8'd0) begin bad++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        total++; if (fsm_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 8'd0;
    endtask

    task automatic test_add();
        logic took;
        int   cyc;
        out_ready = 1'b1;
        send_req(4'h0, 4'd7, 4'd1, 2'd2, took);
        total++; if (took !== 1'b1) begin bad++; $display("FAIL add_accept: got %0b want 1", took); end
        wait_valid(cyc);
        total++; if (cyc != 2) begin bad++; $display("FAIL add_latency: got %0d want 2", cyc); end
        total++; if (out_y !== 8'h08) begin bad++; $display("FAIL add_y: got %0h want 08", out_y); end
        total++; if (out_tag !== 2'd2) begin bad++; $display("FAIL add_tag: got %0d want 2", out_tag); end
        take_result();
        total++; if (op_count !== exp_count) begin bad++; $display("FAIL add_count: got %0d want %0d", op_count, exp_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_valid_drop: got %0b want 0", out_valid); end
    endtask

    task automatic test_sub();
        logic took;
        int   cyc;
        out_ready = 1'b1;
        send_req(4'h2, 4'd3, 4'b1000, 2'd1, took);
        wait_valid(cyc);
        total++; if (cyc != 2) begin bad++; $display("FAIL sub_latency: got %0d want 2", cyc); end
        total++; if (out_y !== 8'hF5) begin bad++; $display("FAIL sub_y: got %0h want f5", out_y); end
        take_result();
        total++; if (op_count !== exp_count) begin bad++; $display("FAIL sub_count: got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_mul();
        logic [3:0] ma[3] = '{4'h8, 4'h8, 4'h0};
        logic [3:0] mb[3] = '{4'h8, 4'h7, 4'hB};
        logic [7:0] my[3] = '{8'h40, 8'hC8, 8'h00};
        logic       took;
        int         cyc;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_req(4'h7, ma[i], mb[i], 2'(i), took);
            wait_valid(cyc);
            total++; if (cyc != W + 1) begin bad++; $display("FAIL mul%0d_latency: got %0d want %0d", i, cyc, W + 1); end
            total++; if (out_y !== my[i]) begin bad++; $display("FAIL mul%0d_y: got %0h want %0h", i, out_y, my[i]); end
            total++; if (out_tag !== 2'(i)) begin bad++; $display("FAIL mul%0d_tag: got %0d want %0d", i, out_tag, i); end
            take_result();
        end
        total++; if (op_count !== exp_count) begin bad++; $display("FAIL mul_count: got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_backpressure();
        logic took;
        int   cyc;
        out_ready = 1'b0;
        send_req(4'h8, 4'b0101, 4'h0, 2'd3, took);
        wait_valid(cyc);
        total++; if (cyc != 2) begin bad++; $display("FAIL bp_latency: got %0d want 2", cyc); end
        total++; if (out_y !== 8'h0A) begin bad++; $display("FAIL bp_y: got %0h want 0a", out_y); end
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_sel = 4'($urandom_range(0, 15));
            in_a   = 4'($urandom_range(0, 15));
            in_b   = 4'($urandom_range(0, 15));
            @(negedge clk);
            total++; if (out_y !== 8'h0A || out_tag !== 2'd3) begin bad++; $display("FAIL bp_hold%0d: got %0h/%0d want 0a/3", i, out_y, out_tag); end
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_flags%0d: got ready=%0b valid=%0b want 0/1", i, in_ready, out_valid); end
        end
        in_valid = 1'b0;
        take_result();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_consume: got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
        total++; if (op_count !== exp_count) begin bad++; $display("FAIL bp_count: got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_sel    = 4'hF;
        in_a      = 4'd6;
        in_b      = 4'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_a = 4'd3;
        in_b = 4'd5;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_y !== 8'h0F) begin bad++; $display("FAIL b2b_first: got valid=%0b y=%0h want 1/0f", out_valid, out_y); end
        @(negedge clk);
        exp_count = exp_count + 8'd1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_bypass: got ready=%0b valid=%0b want 1/0", in_ready, out_valid); end
        total++; if (op_count !== exp_count) begin bad++; $display("FAIL b2b_count: got %0d want %0d", op_count, exp_count); end
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept: got %0b want 0", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_y !== 8'h09) begin bad++; $display("FAIL b2b_second: got valid=%0b y=%0h want 1/09", out_valid, out_y); end
        take_result();
    endtask

    task automatic test_reset_mid_mul();
        logic took;
        int   cyc;
        out_ready = 1'b1;
        send_req(4'h7, 4'd3, 4'd2, 2'd0, took);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmul_valid: got %0b want 0", out_valid); end
        total++; if (op_count !== 8'd0) begin bad++; $display("FAIL rmul_count: got %0d want 0", op_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmul_ready: got %0b want 1", in_ready); end
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 8'd0;
        repeat (6) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmul_discard: got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
        end
        send_req(4'h0, 4'd1, 4'd1, 2'd1, took);
        wait_valid(cyc);
        total++; if (cyc != 2) begin bad++; $display("FAIL rmul_add_latency: got %0d want 2", cyc); end
        total++; if (out_y !== 8'h02) begin bad++; $display("FAIL rmul_add_y: got %0h want 02", out_y); end
        take_result();
        total++; if (op_count !== exp_count) begin bad++; $display("FAIL rmul_add_count: got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_random();
        logic [3:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] tag;
        logic [7:0] exp_y;
        logic       took;
        int         cyc;
        int         hold;
        for (int i = 0; i < 60; i++) begin
            sel = 4'($urandom_range(0, 15));
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            tag = 2'($urandom_range(0, 3));
            out_ready = 1'b0;
            exp_q.push_back(model(sel, a, b));
            send_req(sel, a, b, tag, took);
            total++; if (took !== 1'b1) begin bad++; $display("FAIL rnd%0d_accept: got %0b want 1", i, took); end
            wait_valid(cyc);
            exp_y = exp_q.pop_front();
            total++; if (cyc != ((sel == 4'h7) ? W + 1 : 2)) begin bad++; $display("FAIL rnd%0d_latency: sel=%0h got %0d", i, sel, cyc); end
            total++; if (out_y !== exp_y || out_tag !== tag) begin bad++; $display("FAIL rnd%0d_y: sel=%0h a=%0h b=%0h got %0h/%0d want %0h/%0d", i, sel, a, b, out_y, out_tag, exp_y, tag); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                total++; if (out_valid !== 1'b1 || out_y !== exp_y) begin bad++; $display("FAIL rnd%0d_hold: got %0b/%0h want 1/%0h", i, out_valid, out_y, exp_y); end
            end
            take_result();
            total++; if (op_count !== exp_count) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", i, op_count, exp_count); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_y;
        logic       took;
        int         cyc;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 8'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sel   = 4'($urandom_range(0, 15));
            a     = 4'($urandom_range(0, 15));
            b     = 4'($urandom_range(0, 15));
            exp_y = model(sel, a, b);
            send_req(sel, a, b, 2'd0, took);
            wait_valid(cyc);
            total++; if (out_y !== exp_y) begin bad++; $display("FAIL wrap%0d_y: got %0h want %0h", i, out_y, exp_y); end
            take_result();
            if (i == 254) begin
                total++; if (op_count !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", op_count); end
            end
        end
        total++; if (op_count !== 8'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", op_count); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
